// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage: PC, imem handshake, next-PC on retire
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_unit_if.master      imem,
   output logic [31:0]       instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              is_jump,
   input  logic              is_branch,
   input  logic              branch_taken,
   input  logic [25:0]       addr26,
   input  logic [15:0]       imm16,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic [31:0]       retired_count
);

   // The low two address bits are never honoured: instructions are word aligned.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        fetch_done;
   logic        retire;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;
   logic        req_q;
   logic        valid_q;
   logic [31:0] seq_pc;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

   // State register; reset parks the FSM in RESET until rst_n is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the fetch-complete and retire strobes; ack and ready only count in their own state.
   always_comb begin
      state_d    = state_q;
      fetch_done = 1'b0;
      retire     = 1'b0;
      case (state_q)
         ST_RESET: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem.imem_ack) begin
               fetch_done = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (instr_ready) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   // Next PC selection: jump beats taken branch beats sequential; all arithmetic wraps at 2^32.
   always_comb begin
      seq_pc     = pc_q + 32'd4;
      branch_off = {{14{imm16[15]}}, imm16, 2'b00};
      next_pc    = seq_pc;
      if (is_jump) begin
         next_pc = {seq_pc[31:28], addr26, 2'b00};
      end else if (is_branch && branch_taken) begin
         next_pc = seq_pc + branch_off;
      end
   end

   // Datapath: request follows the state we are entering, instruction latched on ack, PC and count advance on retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC_ALIGNED;
         instr_q   <= 32'd0;
         retired_q <= 32'd0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         req_q <= (state_d == ST_FETCH);
         if (fetch_done) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
         end
         if (retire) begin
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instruction    = instr_q;
   assign instr_valid    = valid_q;
   assign pc             = pc_q;
   assign pc_plus4       = seq_pc;
   assign retired_count  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a next-PC reference model
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0040;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic        is_jump;
   logic        is_branch;
   logic        branch_taken;
   logic [25:0] addr26;
   logic [15:0] imm16;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired_count;

   int tests_run;
   int tests_failed;

   logic [31:0] exp_pc;
   logic [31:0] exp_count;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (bus.master),
      .instruction   (instruction),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .is_jump       (is_jump),
      .is_branch     (is_branch),
      .branch_taken  (branch_taken),
      .addr26        (addr26),
      .imm16         (imm16),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .retired_count (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic j, input logic b,
                                                 input logic t, input logic [25:0] a26, input logic [15:0] i16);
      logic [31:0]        seq;
      logic signed [31:0] off;
      seq = cur + 32'd4;
      off = 32'($signed(i16));
      if (j) return (seq & 32'hF000_0000) | ({6'd0, a26} * 32'd4);
      if (b && t) return seq + 32'(off * 32'sd4);
      return seq;
   endfunction

   // Runs one instruction from a FETCH-state negedge to the next FETCH-state negedge.
   task automatic run_instr(input int wait_cyc, input int stall_cyc, input logic j, input logic b,
                            input logic t, input logic [25:0] a26, input logic [15:0] i16, input bit force_wrap);
      logic [31:0] word;
      word = $urandom;
      check("req_in_fetch", {31'd0, bus.imem_req}, 32'd1);
      check("addr_in_fetch", bus.imem_addr, exp_pc);
      check("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
      for (int w = 0; w < wait_cyc; w++) begin
         bus.imem_ack = 1'b0;
         instr_ready  = $urandom_range(0, 1);
         @(posedge clk); @(negedge clk);
         check("addr_stable_wait", bus.imem_addr, exp_pc);
         check("valid_low_wait", {31'd0, instr_valid}, 32'd0);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      instr_ready    = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.imem_ack = 1'b0;
      instr_ready  = 1'b0;
      check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
      check("instr_latched", instruction, word);
      check("req_low_issue", {31'd0, bus.imem_req}, 32'd0);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      for (int s = 0; s < stall_cyc; s++) begin
         bus.imem_ack   = $urandom_range(0, 1);
         bus.imem_rdata = $urandom;
         is_jump        = $urandom_range(0, 1);
         is_branch      = $urandom_range(0, 1);
         branch_taken   = $urandom_range(0, 1);
         addr26         = 26'($urandom);
         imm16          = 16'($urandom);
         @(posedge clk); @(negedge clk);
         check("instr_stable_stall", instruction, word);
         check("pc_stable_stall", pc, exp_pc);
         check("valid_stable_stall", {31'd0, instr_valid}, 32'd1);
      end
      if (force_wrap) begin
         force dut.retired_q = 32'hFFFF_FFFF;
         #1;
         release dut.retired_q;
         exp_count = 32'hFFFF_FFFF;
         check("count_preset", retired_count, exp_count);
      end
      bus.imem_ack = 1'b0;
      instr_ready  = 1'b1;
      is_jump      = j;
      is_branch    = b;
      branch_taken = t;
      addr26       = a26;
      imm16        = i16;
      @(posedge clk); @(negedge clk);
      instr_ready = 1'b0;
      exp_pc      = model_next_pc(exp_pc, j, b, t, a26, i16);
      exp_count   = exp_count + 32'd1;
      check("valid_low_after_retire", {31'd0, instr_valid}, 32'd0);
      check("req_after_retire", {31'd0, bus.imem_req}, 32'd1);
      check("retired_count", retired_count, exp_count);
      check("next_addr", bus.imem_addr, exp_pc);
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      is_jump        = 1'b0;
      is_branch      = 1'b0;
      branch_taken   = 1'b0;
      addr26         = 26'd0;
      imm16          = 16'd0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'd0;
      exp_pc         = RST_PC;
      exp_count      = 32'd0;

      @(negedge clk); @(negedge clk);
      check("rst_pc", pc, RST_PC);
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instruction, 32'd0);
      check("rst_count", retired_count, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);

      // Back-to-back sequential fetches 0x40, 0x44, 0x48.
      for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0);
      check("three_retired", retired_count, 32'd3);

      // Slow memory and stalled core: one retire.
      run_instr(3, 2, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0);
      check("one_more_retire", retired_count, 32'd4);

      // Branch at 0x100 taken backwards, then not taken.
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 26'h000_0040, 16'd0, 1'b0);
      check("at_0x100", bus.imem_addr, 32'h0000_0100);
      run_instr(0, 0, 1'b0, 1'b1, 1'b1, 26'd0, 16'hFFFE, 1'b0);
      check("branch_taken_back", bus.imem_addr, 32'h0000_00FC);
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 26'h000_0040, 16'd0, 1'b0);
      run_instr(1, 1, 1'b0, 1'b1, 1'b0, 26'd0, 16'hFFFE, 1'b0);
      check("branch_not_taken", bus.imem_addr, 32'h0000_0104);

      // Climb to 0x1000_0010, then jump within that region, with and without a competing branch.
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, 16'd0, 1'b0);
      for (int k = 0; k < 5; k++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0);
      check("at_0x10000010", bus.imem_addr, 32'h1000_0010);
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 26'h000_0040, 16'd0, 1'b0);
      check("jump_target", bus.imem_addr, 32'h1000_0100);
      run_instr(0, 0, 1'b1, 1'b1, 1'b1, 26'h000_0080, 16'h0010, 1'b0);
      check("jump_beats_branch", bus.imem_addr, 32'h1000_0200);

      // Reset asserted mid-FETCH while memory acks.
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst_pc", pc, RST_PC);
      check("midrst_count", retired_count, 32'd0);
      check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("restart_req", {31'd0, bus.imem_req}, 32'd1);
      check("restart_valid", {31'd0, instr_valid}, 32'd0);
      check("restart_addr", bus.imem_addr, RST_PC);
      bus.imem_ack = 1'b0;
      exp_pc       = RST_PC;
      exp_count    = 32'd0;

      // Reach 0xFFFF_FFFC via a wrapping backward branch from 0, then wrap sequentially; wrap the counter too.
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 26'd0, 16'd0, 1'b0);
      run_instr(0, 0, 1'b0, 1'b1, 1'b1, 26'd0, 16'hFFFE, 1'b0);
      check("at_top", bus.imem_addr, 32'hFFFF_FFFC);
      run_instr(0, 1, 1'b0, 1'b0, 1'b0, 26'd0, 16'd0, 1'b1);
      check("pc_wrap", bus.imem_addr, 32'h0000_0000);
      check("count_wrap", retired_count, 32'h0000_0000);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                   26'($urandom), 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
